// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, registered
// one-cycle data-valid and framing-error pulses.
module uart_rx #(
  parameter int unsigned c_CYCLES_PER_BIT = 434
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_SERIAL_DATA,
  output logic [7:0] o_PARALLEL_DATA,
  output logic       o_RX_DV,
  output logic       o_RX_ACTIVE,
  output logic       o_FRAME_ERR
);

  localparam int unsigned CNT_W = (c_CYCLES_PER_BIT > 2) ? $clog2(c_CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((c_CYCLES_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(c_CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_n;
  logic             dv_n, ferr_n;

  logic             sync_meta, sync_rx, rx_prev;
  logic             fall;

  // rx_prev holds the previous synchronized sample for edge detection only
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sync_meta <= 1'b1;
      sync_rx   <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= i_SERIAL_DATA;
      sync_rx   <= sync_meta;
      rx_prev   <= sync_rx;
    end
  end

  assign fall = rx_prev & ~sync_rx;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      o_PARALLEL_DATA <= '0;
      o_RX_DV         <= 1'b0;
      o_FRAME_ERR     <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      bit_idx         <= bit_idx_n;
      shreg           <= shreg_n;
      o_PARALLEL_DATA <= data_n;
      o_RX_DV         <= dv_n;
      o_FRAME_ERR     <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = o_PARALLEL_DATA;
    dv_n      = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (fall) state_n = START;
      end

      START: begin
        if (cnt == HALF_CNT) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = sync_rx ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = sync_rx;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (sync_rx) begin
            data_n = shreg;
            dv_n   = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
          state_n = CLEANUP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Pulses drop via their defaults; one cycle here leaves room for a
      // back-to-back start edge.
      CLEANUP: begin
        state_n = IDLE;
      end

      default: begin
        state_n   = IDLE;
        cnt_n     = '0;
        bit_idx_n = '0;
      end
    endcase
  end

  always_comb begin
    o_RX_ACTIVE = 1'b0;
    if (state == START || state == DATA || state == STOP) o_RX_ACTIVE = 1'b1;
  end

endmodule
